// File: rtl/bin_rgb_render.sv
// Binary-to-RGB565 renderer with two-stage pipeline and scan-row dark-pixel counter.
// Optional scan-row marker enabled by defining BIN_RENDER_SCANLINE_EN.
module bin_rgb_render #(
  parameter int          H_ACTIVE   = 800,
  parameter int          V_ACTIVE   = 480,
  parameter logic [15:0] FG_COLOR   = 16'h0000,
  parameter logic [15:0] BG_COLOR   = 16'hFFFF,
  parameter logic [15:0] MARK_COLOR = 16'hF800,
  parameter int          SCAN_ROW   = 240
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bin_data,
  input  logic        bin_de,
  input  logic        bin_hs,
  input  logic        bin_vs,
  output logic [15:0] out_data,
  output logic        out_de,
  output logic        out_hs,
  output logic        out_vs,
  output logic [10:0] row_cnt,
  output logic        row_valid
);

  localparam logic [10:0] CNT_MAX = 11'h7FF;
  localparam logic [10:0] SCAN_Y  = 11'(SCAN_ROW);

  logic        s1_data, s1_de, s1_hs, s1_vs;
  logic [10:0] x_cnt, y_cnt;
  logic [10:0] x_next, y_next;
  logic [10:0] acc, acc_next, acc_base, acc_fin;
  logic        de_fall, vs_rise, meas_on, latch, latch_pend;
  logic [15:0] light_color;

  // Edges are taken against the stage-1 copies, so vs high at reset release is a rise.
  assign de_fall = s1_de & ~bin_de;
  assign vs_rise = bin_vs & ~s1_vs;

  always_comb begin
    x_next = x_cnt;
    if (bin_de) begin
      if (!s1_de)              x_next = '0;
      else if (x_cnt != CNT_MAX) x_next = x_cnt + 11'd1;
    end else if (de_fall) begin
      x_next = '0;
    end
  end

  always_comb begin
    y_next = y_cnt;
    if (vs_rise)                         y_next = '0;
    else if (de_fall && y_cnt != CNT_MAX) y_next = y_cnt + 11'd1;
  end

  // A vs rise on the closing edge of the scan row aborts instead of latching.
  assign meas_on  = bin_de && (y_next == SCAN_Y);
  assign latch    = de_fall && (y_cnt == SCAN_Y) && !vs_rise;
  assign acc_base = (vs_rise || latch) ? 11'd0 : acc;

  always_comb begin
    acc_next = acc_base;
    if (meas_on && bin_data && acc_base != CNT_MAX) acc_next = acc_base + 11'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_data    <= 1'b0;
      s1_de      <= 1'b0;
      s1_hs      <= 1'b0;
      s1_vs      <= 1'b0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      acc        <= '0;
      acc_fin    <= '0;
      latch_pend <= 1'b0;
    end else begin
      s1_data    <= bin_data;
      s1_de      <= bin_de;
      s1_hs      <= bin_hs;
      s1_vs      <= bin_vs;
      x_cnt      <= x_next;
      y_cnt      <= y_next;
      acc        <= acc_next;
      latch_pend <= latch;
      if (latch) acc_fin <= acc;
    end
  end

`ifdef BIN_RENDER_SCANLINE_EN
  assign light_color = (y_cnt == SCAN_Y) ? MARK_COLOR : BG_COLOR;
`else
  assign light_color = BG_COLOR;
`endif

  // Stage 2: row_cnt/row_valid share this stage so they line up with out_de.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_de    <= 1'b0;
      out_hs    <= 1'b0;
      out_vs    <= 1'b0;
      row_cnt   <= '0;
      row_valid <= 1'b0;
    end else begin
      out_data  <= s1_de ? (s1_data ? FG_COLOR : light_color) : 16'h0000;
      out_de    <= s1_de;
      out_hs    <= s1_hs;
      out_vs    <= s1_vs;
      row_valid <= latch_pend;
      if (latch_pend) row_cnt <= acc_fin;
    end
  end

endmodule

// File: tb/tb_bin_rgb_render.sv
// Directed bench for bin_rgb_render: reset, latency/mapping, scan-row measurement,
// marker (follows BIN_RENDER_SCANLINE_EN), abort and saturation.
module tb_bin_rgb_render;

  logic        clk = 1'b0;
  logic        rst_n, bin_data, bin_de, bin_hs, bin_vs;
  logic [15:0] out_data;
  logic        out_de, out_hs, out_vs;
  logic [10:0] row_cnt;
  logic        row_valid;

  int checks   = 0;
  int failures = 0;
  int rv_count = 0;

  logic [18:0] prev_exp;
  logic        on_scan = 1'b0;

`ifdef BIN_RENDER_SCANLINE_EN
  localparam bit MARK_EN = 1'b1;
`else
  localparam bit MARK_EN = 1'b0;
`endif

  bin_rgb_render dut (
    .clk(clk), .rst_n(rst_n), .bin_data(bin_data), .bin_de(bin_de),
    .bin_hs(bin_hs), .bin_vs(bin_vs), .out_data(out_data), .out_de(out_de),
    .out_hs(out_hs), .out_vs(out_vs), .row_cnt(row_cnt), .row_valid(row_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (row_valid === 1'b1) rv_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One pixel cycle; outputs after the edge reflect the pixel driven one call earlier.
  task automatic px(input logic de, input logic hs, input logic vs, input logic d);
    logic [18:0] cur;
    logic [15:0] col;
    bin_de = de; bin_hs = hs; bin_vs = vs; bin_data = d;
    col = !de ? 16'h0000 : (d ? 16'h0000 : ((on_scan && MARK_EN) ? 16'hF800 : 16'hFFFF));
    cur = {de, hs, vs, col};
    @(posedge clk); #1;
    chk("pixel", 32'({out_de, out_hs, out_vs, out_data}), 32'(prev_exp));
    prev_exp = cur;
  endtask

  task automatic frame(input int lo, input int hi, input int len, input int abort_at,
                       input logic [10:0] exp_cnt, input int exp_pulses);
    int   base;
    logic v;
    px(0, 0, 1, 0); px(0, 0, 1, 0);
    px(0, 0, 0, 0); px(0, 0, 0, 0);
    for (int r = 0; r < 240; r++) begin
      px(1, 0, 0, 0); px(1, 0, 0, 1); px(0, 1, 0, 0);
    end
    base = rv_count;
    v = 1'b0;
    on_scan = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) begin v = 1'b1; on_scan = 1'b0; end
      px(1, 0, v, (i >= lo && i <= hi));
    end
    on_scan = 1'b0;
    if (abort_at == len) v = 1'b1;
    px(0, 0, v, 0);
    chk("row_valid_early", 32'(row_valid), 32'd0);
    px(0, 0, v, 0);
    chk("row_valid_pulse", 32'(row_valid), 32'(exp_pulses == 1));
    chk("row_cnt", 32'(row_cnt), 32'(exp_cnt));
    px(0, 0, v, 0);
    chk("row_valid_after", 32'(row_valid), 32'd0);
    px(0, 0, 0, 0); px(0, 0, 0, 0);
    chk("row_valid_count", 32'(rv_count - base), 32'(exp_pulses));
    chk("row_cnt_hold", 32'(row_cnt), 32'(exp_cnt));
  endtask

  initial begin
    rst_n = 1'b0; bin_data = 1'b0; bin_de = 1'b0; bin_hs = 1'b0; bin_vs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bin_data = 1'($urandom_range(0, 1));
      bin_de   = 1'($urandom_range(0, 1));
      bin_hs   = 1'($urandom_range(0, 1));
      bin_vs   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("reset_outputs", 32'({out_de, out_hs, out_vs, out_data}), 32'd0);
      chk("reset_row", 32'({row_valid, row_cnt}), 32'd0);
    end
    bin_data = 1'b0; bin_de = 1'b0; bin_hs = 1'b0; bin_vs = 1'b0;
    @(posedge clk); #1;
    chk("reset_no_pulse", 32'(rv_count), 32'd0);
    rst_n = 1'b1;
    prev_exp = '0;

    // Latency and colour mapping, with hs toggled to check alignment.
    px(0, 1, 0, 0); px(0, 0, 0, 1);
    px(1, 0, 0, 1); px(1, 0, 0, 0); px(1, 0, 0, 1);
    px(0, 1, 0, 0); px(0, 0, 0, 0); px(0, 0, 0, 0);

    frame(1, 0, 800, -1, 11'd0, 1);        // all light: marker or background
    frame(100, 149, 800, -1, 11'd50, 1);   // 50 dark pixels
    frame(100, 149, 800, 400, 11'd50, 0);  // vs rises mid scan row
    frame(0, 799, 800, 800, 11'd50, 0);    // vs rise coincides with de fall
    frame(0, 2099, 2100, -1, 11'd2047, 1); // saturation

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin_rgb_render.md
BIN_RGB_RENDER -- requirements
Module: bin_rgb_render

Interface
REQ-001 Parameter H_ACTIVE, 800: active pixels per line; sizes the x counter.
REQ-002 Parameter V_ACTIVE, 480: active lines per frame; sizes the y counter.
REQ-003 Parameter FG_COLOR, 16'h0000: RGB565 colour output for a bin_data=1 pixel.
REQ-004 Parameter BG_COLOR, 16'hFFFF: RGB565 colour output for a bin_data=0 pixel.
REQ-005 Parameter MARK_COLOR, 16'hF800: RGB565 colour of the scan-row marker.
REQ-006 Parameter SCAN_ROW, 240: line index, 0-based, that is measured and marked.
REQ-007 clk  input  1: single pixel clock; all logic is on its rising edge.
REQ-008 rst_n  input  1: reset, synchronous, active-low.
REQ-009 bin_data  input  1: thresholded pixel, 1 = dark; valid only while bin_de=1.
REQ-010 bin_de, bin_hs, bin_vs  input  1 each: timing of the binary stream; bin_vs is active-high.
REQ-011 out_data  output  16: rendered RGB565 pixel.
REQ-012 out_de, out_hs, out_vs  output  1 each: bin_de, bin_hs and bin_vs delayed to align with out_data.
REQ-013 row_cnt  output  11: number of dark pixels on SCAN_ROW in the last completed measurement.
REQ-014 row_valid  output  1: one-cycle pulse when row_cnt updates.

Function
REQ-015 Fixed latency of exactly 2 clk cycles from bin_* to out_data, out_de, out_hs and out_vs, all outputs aligned.
REQ-016 Stage 1 registers the bin_* inputs, the x counter value and the y counter value; stage 2 computes out_data from the stage-1 values.
REQ-017 x_cnt is 11 bits: 0 at the first bin_de=1 cycle of a line, +1 per bin_de=1 cycle, cleared on the bin_de falling edge, saturates at 2047.
REQ-018 y_cnt is 11 bits: +1 on each bin_de falling edge, cleared on the bin_vs rising edge, saturates at 2047.
REQ-019 Simultaneous bin_vs rise and bin_de falling edge: the clear wins, so y_cnt = 0.
REQ-020 Pixel mapping: de=0 gives 16'h0000; de=1 with bin_data=1 gives FG_COLOR; de=1 with bin_data=0 gives BG_COLOR.
REQ-021 Measurement: while y_cnt == SCAN_ROW and bin_de=1, an 11-bit accumulator adds bin_data each cycle, saturating at 2047.
REQ-022 On the bin_de falling edge of SCAN_ROW, the final accumulator value, including the last pixel, is latched into row_cnt.
REQ-023 row_valid is high for exactly one cycle, the cycle row_cnt updates.
REQ-024 The accumulator clears on the bin_vs rising edge and after each latch.
REQ-025 A bin_vs rise during SCAN_ROW aborts the measurement: no latch, no row_valid, row_cnt holds its old value.
REQ-026 Lines beyond V_ACTIVE and pixels beyond H_ACTIVE are rendered per REQ-020 without error; counters saturate only per REQ-017/REQ-018.
REQ-027 No handshake or back-pressure: one pixel is accepted and emitted every cycle.

Reset
REQ-028 While rst_n=0 at a clk edge, the module SHALL set: out_data=0, out_de=0, out_hs=0, out_vs=0, row_cnt=0, row_valid=0, x_cnt=0, y_cnt=0, accumulator=0, all pipeline registers 0.
REQ-029 After reset the first bin_vs rising edge is detected relative to the reset value 0, so vs already high at release counts as a rise.
REQ-030 Reset asserted mid-frame discards the partial measurement; rendering resumes 2 cycles after release.

Configuration
REQ-031 Macro BIN_RENDER_SCANLINE_EN defined: stage 2 outputs MARK_COLOR for de=1, bin_data=0 pixels on row SCAN_ROW; dark pixels on that row stay FG_COLOR.
REQ-032 Macro BIN_RENDER_SCANLINE_EN undefined: no marker; SCAN_ROW renders per REQ-020; measurement per REQ-021 to REQ-025 is unchanged; latency is unchanged.

Verification
REQ-033 Reset: rst_n=0 for 3 cycles with random inputs -> all outputs 0; row_valid never pulses.
REQ-034 Latency/mapping: de=1 with bin_data=1,0,1 at cycles 10..12 -> out_data=0000,FFFF,0000 at cycles 12..14; out_de high at 12..14.
REQ-035 Measurement: 800-pixel frame, row 240 with pixels 100..149 dark -> row_cnt=50 with a single row_valid pulse 2 cycles after that line's de falls.
REQ-036 Marker: BIN_RENDER_SCANLINE_EN defined, row 240 all light -> out_data=F800 for all 800 pixels; with the macro undefined -> FFFF.
REQ-037 Abort: bin_vs rises at pixel 400 of row 240 -> no row_valid; row_cnt keeps the previous value; next frame row 0 counts from x=0.
REQ-038 Saturation: 2100 consecutive dark pixels on SCAN_ROW -> row_cnt=2047.
